// File: rtl/morse_char_sequencer_pkg.sv
// morse_char_sequencer_pkg: shared constants and FSM state type for the morse character path
package morse_char_sequencer_pkg;
  localparam int MAX_SYMBOLS = 5;
  localparam logic [7:0] SPACE_ADDR = 8'hE0;
  localparam logic [7:0] ERR_ADDR = 8'hC0;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITE, SP_LOOKUP, SP_WRITE} seq_state_t;
endpackage

// File: rtl/morse_char_sequencer_if.sv
// morse_char_sequencer_if: ROM lookup and FIFO write bus between sequencer and char datapath
interface morse_char_sequencer_if;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic fifo_full;
  logic fifo_wr_en;
  logic [7:0] fifo_din;
  modport master(output rom_addr, fifo_wr_en, fifo_din, input rom_data, fifo_full);
  modport slave(input rom_addr, fifo_wr_en, fifo_din, output rom_data, fifo_full);
endinterface

// File: rtl/morse_char_sequencer_accumulator.sv
// morse_char_sequencer_accumulator: symbol shift register, saturating count, sticky overflow, clear on gap
module morse_char_sequencer_accumulator
  import morse_char_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dot,
  input  logic       dash,
  input  logic       clr,
  output logic [4:0] sym_bits,
  output logic [2:0] sym_count,
  output logic [4:0] sym_enable,
  output logic       overflow
);
  logic sym;
  logic [4:0] b0;
  logic [2:0] c0;
  logic o0;
  assign sym = dot ^ dash;
  // a symbol arriving on the clearing cycle starts the next letter
  always_comb begin
    b0 = clr ? 5'd0 : sym_bits;
    c0 = clr ? 3'd0 : sym_count;
    o0 = clr ? 1'b0 : overflow;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_bits <= '0;
      sym_count <= '0;
      overflow <= 1'b0;
    end else begin
      sym_bits <= sym ? {b0[3:0], dash} : b0;
      sym_count <= (sym && c0 != 3'(MAX_SYMBOLS)) ? c0 + 3'd1 : c0;
      overflow <= o0 | (sym && c0 == 3'(MAX_SYMBOLS));
    end
  end
  assign sym_enable = 5'((6'd1 << sym_count) - 6'd1);
endmodule

// File: rtl/morse_char_sequencer.sv
// morse_char_sequencer: turns symbol/gap pulses into ROM lookups and one FIFO write per character
module morse_char_sequencer
  import morse_char_sequencer_pkg::*;
#(
  parameter int ROM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dot,
  input  logic                          dash,
  input  logic                          lg,
  input  logic                          wg,
  morse_char_sequencer_if.master        bus,
  output logic [4:0]                    sym_bits,
  output logic [2:0]                    sym_count,
  output logic [4:0]                    sym_enable,
  output logic                          busy,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);
  localparam logic [1:0] LAT0 = 2'(ROM_LATENCY - 1);
  seq_state_t state;
  logic [7:0] rom_addr;
  logic [1:0] lat;
  logic space_pending;
  logic last_space;
  logic gap;
  logic wr;
  assign gap = lg | wg;
  assign wr = state == WRITE || state == SP_WRITE;
  morse_char_sequencer_accumulator u_acc (
    .clk(clk), .reset(reset), .dot(dot), .dash(dash), .clr(gap && state == IDLE),
    .sym_bits(sym_bits), .sym_count(sym_count), .sym_enable(sym_enable), .overflow(overflow)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rom_addr <= '0;
      lat <= '0;
      space_pending <= 1'b0;
      last_space <= 1'b1;
      drop_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gap && sym_count != 3'd0) begin
            rom_addr <= overflow ? ERR_ADDR : {sym_count, sym_bits};
            lat <= LAT0;
            space_pending <= wg;
            state <= LOOKUP;
          end else if (wg && !last_space) begin
            rom_addr <= SPACE_ADDR;
            lat <= LAT0;
            state <= SP_LOOKUP;
          end
        end
        LOOKUP: begin
          lat <= lat - 2'd1;
          if (lat == 2'd0) state <= WRITE;
        end
        SP_LOOKUP: begin
          lat <= lat - 2'd1;
          if (lat == 2'd0) state <= SP_WRITE;
        end
        WRITE: begin
          if (bus.fifo_full && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          last_space <= 1'b0;
          if (space_pending) begin
            rom_addr <= SPACE_ADDR;
            lat <= LAT0;
            state <= SP_LOOKUP;
          end else state <= IDLE;
        end
        SP_WRITE: begin
          if (bus.fifo_full && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          last_space <= 1'b1;
          space_pending <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign bus.rom_addr = rom_addr;
  assign bus.fifo_wr_en = wr & ~bus.fifo_full;
  assign bus.fifo_din = bus.fifo_wr_en ? bus.rom_data : 8'd0;
endmodule

// File: tb/tb_morse_char_sequencer.sv
// tb_morse_char_sequencer: directed checks on two sequencers (ROM latency 1 and 2) sharing stimulus
module tb_morse_char_sequencer;
  logic clk = 0, reset = 1, dot = 0, dash = 0, lg = 0, wg = 0, full = 0;
  logic [4:0] sb1, se1, sb2, se2;
  logic [2:0] sc1, sc2;
  logic bz1, ov1, bz2, ov2;
  logic [7:0] dc1, dc2, r1a, r2a, r2b;
  int cyc = 0, total = 0, bad = 0, g;
  int wt1[$], wt2[$];
  logic [7:0] wd1[$], wd2[$];
  morse_char_sequencer_if bus1();
  morse_char_sequencer_if bus2();
  morse_char_sequencer #(.ROM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .dot(dot), .dash(dash), .lg(lg), .wg(wg), .bus(bus1.master),
    .sym_bits(sb1), .sym_count(sc1), .sym_enable(se1), .busy(bz1), .overflow(ov1), .drop_count(dc1));
  morse_char_sequencer #(.ROM_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .dot(dot), .dash(dash), .lg(lg), .wg(wg), .bus(bus2.master),
    .sym_bits(sb2), .sym_count(sc2), .sym_enable(se2), .busy(bz2), .overflow(ov2), .drop_count(dc2));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    r1a <= bus1.rom_addr ^ 8'h5A;
    r2a <= bus2.rom_addr ^ 8'h5A;
    r2b <= r2a;
  end
  assign bus1.rom_data = r1a;
  assign bus2.rom_data = r2b;
  assign bus1.fifo_full = full;
  assign bus2.fifo_full = full;
  always @(negedge clk) begin
    if (bus1.fifo_wr_en) begin wt1.push_back(cyc); wd1.push_back(bus1.fifo_din); end
    if (bus2.fifo_wr_en) begin wt2.push_back(cyc); wd2.push_back(bus2.fifo_din); end
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(logic [3:0] v);
    {dot, dash, lg, wg} = v;
    @(negedge clk);
    {dot, dash, lg, wg} = 4'b0;
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic flush();
    wt1.delete(); wd1.delete(); wt2.delete(); wd2.delete();
  endtask
  task automatic do_reset();
    reset = 1;
    idle(2);
    reset = 0;
    flush();
  endtask
  localparam logic [3:0] DOT = 4'b1000, DASH = 4'b0100, LG = 4'b0010, WG = 4'b0001;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_addr", bus1.rom_addr, 8'h00);
    chk("rst_wr", {bus1.fifo_wr_en, bus2.fifo_wr_en}, 2'b00);
    chk("rst_din", bus1.fifo_din, 8'h00);
    chk("rst_sym", {sb1, sc1, se1}, 13'd0);
    chk("rst_flags", {bz1, ov1, bz2, ov2}, 4'd0);
    chk("rst_drop", {dc1, dc2}, 16'd0);
    reset = 0;
    // letter .-- -> addr 0x63, data 0x39
    drive(DOT); drive(DASH); drive(DASH);
    chk("t1_bits", sb1, 5'b00011);
    chk("t1_count", sc1, 3'd3);
    chk("t1_enable", se1, 5'b00111);
    drive(LG);
    g = cyc;
    chk("t1_addr1", bus1.rom_addr, 8'h63);
    chk("t1_addr2", bus2.rom_addr, 8'h63);
    chk("t1_busy", {bz1, bz2}, 2'b11);
    chk("t1_clr", sc1, 3'd0);
    idle(6);
    chk("t1_n1", wt1.size(), 1);
    chk("t1_n2", wt2.size(), 1);
    chk("t1_d1", wd1[0], 8'h39);
    chk("t1_d2", wd2[0], 8'h39);
    chk("t1_t1", wt1[0], g + 1);
    chk("t1_t2", wt2[0], g + 2);
    chk("t1_idle", {bz1, bz2}, 2'b00);
    flush();
    // dash + word gap -> letter 0x21 then space
    drive(DASH); drive(WG);
    g = cyc;
    idle(10);
    chk("t2_n1", wt1.size(), 2);
    chk("t2_n2", wt2.size(), 2);
    chk("t2_d1a", wd1[0], 8'h7B);
    chk("t2_d1b", wd1[1], 8'hBA);
    chk("t2_d2b", wd2[1], 8'hBA);
    chk("t2_t1", wt1[0], g + 1);
    chk("t2_gap1", wt1[1] - wt1[0], 2);
    chk("t2_gap2", wt2[1] - wt2[0], 3);
    flush();
    drive(WG); idle(6);
    chk("t2_nosp", wt1.size() + wt2.size(), 0);
    // leading word gaps produce nothing; one letter then wg,wg -> one space
    do_reset();
    drive(WG); idle(6); drive(WG); idle(6);
    chk("t3_lead", wt1.size() + wt2.size(), 0);
    drive(DOT); drive(LG); idle(6); drive(WG); idle(8); drive(WG); idle(8);
    chk("t3_n1", wt1.size(), 2);
    chk("t3_n2", wt2.size(), 2);
    chk("t3_d0", wd1[0], 8'h7A);
    chk("t3_d1", wd2[1], 8'hBA);
    flush();
    // six dots -> overflow, error glyph
    repeat (5) drive(DOT);
    chk("t4_ov5", {ov1, sc1}, {1'b0, 3'd5});
    drive(DOT);
    chk("t4_ov6", {ov1, sc1, ov2}, {1'b1, 3'd5, 1'b1});
    drive(LG);
    chk("t4_addr", bus1.rom_addr, 8'hC0);
    chk("t4_addr2", bus2.rom_addr, 8'hC0);
    chk("t4_clr", {ov1, ov2}, 2'b00);
    idle(6);
    chk("t4_d", wd2[0], 8'h9A);
    flush();
    // fifo full -> drops, saturating
    drive(DOT); drive(LG);
    full = 1;
    idle(6);
    chk("t5_nowr", wt1.size() + wt2.size(), 0);
    chk("t5_drop1", dc1, 8'd1);
    chk("t5_drop2", dc2, 8'd1);
    for (int i = 0; i < 300; i++) begin drive(DOT); drive(LG); idle(4); end
    chk("t5_sat1", dc1, 8'hFF);
    chk("t5_sat2", dc2, 8'hFF);
    chk("t5_nowr2", wt1.size() + wt2.size(), 0);
    full = 0;
    // reset during LOOKUP
    drive(DOT); drive(LG);
    chk("t6_busy", {bz1, bz2}, 2'b11);
    reset = 1;
    idle(1);
    chk("t6_busy0", {bz1, bz2}, 2'b00);
    chk("t6_addr", {bus1.rom_addr, bus2.rom_addr}, 16'd0);
    chk("t6_drop", {dc1, dc2}, 16'd0);
    reset = 0;
    idle(6);
    chk("t6_nowr", wt1.size() + wt2.size(), 0);
    // symbol during LOOKUP belongs to the next letter
    drive(DOT); drive(LG); drive(DASH);
    chk("t6_next", {sc1, sb1, sc2, sb2}, {3'd1, 5'd1, 3'd1, 5'd1});
    idle(6);
    flush();
    drive(LG);
    chk("t6_addr2", bus2.rom_addr, 8'h21);
    idle(6);
    chk("t6_d", wd1[0], 8'h7B);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
